branch_predictor_bht: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage RISC pipeline.
- Replaces the static equality-only branch decision with a direct-mapped branch history table (BHT) plus branch target buffer (BTB).
- The IF stage does a same-cycle lookup on the fetch PC. The ID stage, where branches resolve, writes back outcome and target.
- Saturating mispredict/update counters support performance measurement.

---
 rtl/bp_pkg.sv | 34 +++
 rtl/branch_predictor_bht_ctr.sv | 28 ++
 rtl/branch_predictor_bht.sv | 98 +++++++++
 tb/tb_branch_predictor_bht.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared helpers for the BHT/BTB branch predictor: width derivation and
// width-generic saturating counter arithmetic (widths up to 32 bits).
package bp_pkg;

    function automatic int unsigned idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned tag_w(input int unsigned n, input int unsigned entries);
        return n - $clog2(entries);
    endfunction

    function automatic logic [31:0] sat_max(input int unsigned bits);
        return (bits >= 32) ? 32'hFFFF_FFFF : (32'(1) << bits) - 32'(1);
    endfunction

    // Weakly-not-taken and weakly-taken starting points for a CTR_BITS counter
    function automatic logic [31:0] ctr_wn(input int unsigned bits);
        return (32'(1) << (bits - 1)) - 32'(1);
    endfunction

    function automatic logic [31:0] ctr_wt(input int unsigned bits);
        return 32'(1) << (bits - 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned bits);
        return (v >= sat_max(bits)) ? sat_max(bits) : v + 32'(1);
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'(0)) ? 32'(0) : v - 32'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_bht_ctr.sv
// One BHT entry's saturating direction counter: reset to weakly-not-taken,
// load to weakly-taken on allocation, otherwise saturating inc/dec/hold.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    input  logic                load,
    output logic [CTR_BITS-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CTR_BITS'(ctr_wn(CTR_BITS));
        end else if (load) begin
            count <= CTR_BITS'(ctr_wt(CTR_BITS));
        end else if (inc) begin
            count <= CTR_BITS'(sat_inc(32'(count), CTR_BITS));
        end else if (dec) begin
            count <= CTR_BITS'(sat_dec(32'(count)));
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT + BTB: combinational lookup on the fetch PC, registered
// update from the ID-stage branch resolution, saturating perf counters.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     pc_if,
    output logic             predict_taken,
    output logic [N-1:0]     predict_target,
    input  logic             upd_valid,
    input  logic [N-1:0]     upd_pc,
    input  logic             upd_taken,
    input  logic [N-1:0]     upd_target,
    input  logic             upd_predicted,
    output logic [CNT_W-1:0] upd_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX   = idx_w(ENTRIES);
    localparam int unsigned TAG_W = tag_w(N, ENTRIES);

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [N-1:0]        target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr      [ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign lk_idx  = pc_if[IDX-1:0];
    assign lk_tag  = pc_if[N-1:IDX];
    assign upd_idx = upd_pc[IDX-1:0];
    assign upd_tag = upd_pc[N-1:IDX];

    // Lookup reads the pre-edge table, so a same-cycle update is not bypassed
    always_comb begin
        lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        predict_taken  = lk_hit && ctr[lk_idx][CTR_BITS-1];
        predict_target = predict_taken ? target_q[lk_idx] : pc_if + N'(1);
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel;
        assign sel = upd_valid && (upd_idx == IDX'(g));

        bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .inc   (sel && upd_hit && upd_taken),
            .dec   (sel && upd_hit && !upd_taken),
            .load  (sel && !upd_hit && upd_taken),
            .count (ctr[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd_valid && upd_taken && !upd_hit) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // Tags and targets carry no reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            target_q[upd_idx] <= upd_target;
            if (!upd_hit) begin
                tag_q[upd_idx] <= upd_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_count        <= '0;
            mispredict_count <= '0;
        end else if (upd_valid) begin
            upd_count <= CNT_W'(sat_inc(32'(upd_count), CNT_W));
            if (upd_taken != upd_predicted) begin
                mispredict_count <= CNT_W'(sat_inc(32'(mispredict_count), CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Vector/scoreboard bench for branch_predictor_bht: a default instance and a
// CNT_W=4 instance share all stimulus; counts of both are checked.
module tb_branch_predictor_bht;

    localparam int unsigned N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  pc_if;
    logic          upd_valid;
    logic [N-1:0]  upd_pc;
    logic          upd_taken;
    logic [N-1:0]  upd_target;
    logic          upd_predicted;

    logic          pt_a, pt_c;
    logic [N-1:0]  tgt_a, tgt_c;
    logic [15:0]   uc_a, mc_a;
    logic [3:0]    uc_c, mc_c;

    always #5 clk = ~clk;

    branch_predictor_bht u_dut_a (
        .clk              (clk),
        .rst              (rst),
        .pc_if            (pc_if),
        .predict_taken    (pt_a),
        .predict_target   (tgt_a),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_predicted    (upd_predicted),
        .upd_count        (uc_a),
        .mispredict_count (mc_a)
    );

    branch_predictor_bht #(.CNT_W(4)) u_dut_c (
        .clk              (clk),
        .rst              (rst),
        .pc_if            (pc_if),
        .predict_taken    (pt_c),
        .predict_target   (tgt_c),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_predicted    (upd_predicted),
        .upd_count        (uc_c),
        .mispredict_count (mc_c)
    );

    // One cycle of stimulus plus the outputs expected in that same cycle
    typedef struct {
        int          id;
        logic        rst;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upred;
        logic [31:0] pc;
        bit          chk;
        logic        et;
        logic [31:0] etgt;
        int          euc_a;
        int          emc_a;
        int          euc_c;
        int          emc_c;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic r, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic upred,
                                input logic [31:0] pc, input bit chk, input logic et,
                                input logic [31:0] etgt, input int uc, input int mc);
        vec_t v;
        v.id = 0;      v.rst = r;   v.uv = uv;   v.upc = upc;  v.ut = ut;
        v.utgt = utgt; v.upred = upred; v.pc = pc; v.chk = chk;
        v.et = et;     v.etgt = etgt;
        v.euc_a = uc;  v.emc_a = mc; v.euc_c = uc; v.emc_c = mc;
        return v;
    endfunction

    task automatic check(input int id, input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%0h, want 0x%0h", id, nm, got, want);
        end
    endtask

    // Drive just after the rising edge, compare at the falling edge
    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        rst           = v.rst;
        upd_valid     = v.uv;
        upd_pc        = v.upc;
        upd_taken     = v.ut;
        upd_target    = v.utgt;
        upd_predicted = v.upred;
        pc_if         = v.pc;
        if (v.chk) sb_q.push_back(v);
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.id, "taken_a",  32'(pt_a),  32'(e.et));
            check(e.id, "target_a", tgt_a,      e.etgt);
            check(e.id, "taken_c",  32'(pt_c),  32'(e.et));
            check(e.id, "target_c", tgt_c,      e.etgt);
            check(e.id, "upd_cnt_a", 32'(uc_a), 32'(e.euc_a));
            check(e.id, "mis_cnt_a", 32'(mc_a), 32'(e.emc_a));
            check(e.id, "upd_cnt_c", 32'(uc_c), 32'(e.euc_c));
            check(e.id, "mis_cnt_c", 32'(mc_c), 32'(e.emc_c));
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_predicted = 1'b0; pc_if = '0;

        //             rst uv upc     ut utgt   prd pc            chk et etgt          uc mc
        tbl.push_back(mk(1, 0, 32'h0,  0, 32'h0,  0, 32'h40,       0, 0, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h40,       1, 0, 32'h41,       0, 0));
        tbl.push_back(mk(0, 1, 32'h40, 1, 32'h80, 0, 32'h40,       1, 0, 32'h41,       0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h40,       1, 1, 32'h80,       1, 1));
        tbl.push_back(mk(0, 1, 32'h40, 0, 32'h0,  1, 32'h40,       1, 1, 32'h80,       1, 1));
        tbl.push_back(mk(0, 1, 32'h40, 0, 32'h0,  0, 32'h40,       1, 0, 32'h41,       2, 2));
        tbl.push_back(mk(0, 1, 32'h40, 1, 32'h80, 0, 32'h40,       1, 0, 32'h41,       3, 2));
        tbl.push_back(mk(0, 1, 32'h40, 1, 32'h80, 0, 32'h40,       1, 0, 32'h41,       4, 3));
        tbl.push_back(mk(0, 1, 32'h40, 1, 32'h80, 1, 32'h40,       1, 1, 32'h80,       5, 4));
        tbl.push_back(mk(0, 1, 32'h40, 1, 32'h80, 1, 32'h40,       1, 1, 32'h80,       6, 4));
        tbl.push_back(mk(0, 1, 32'h40, 0, 32'h0,  1, 32'h40,       1, 1, 32'h80,       7, 4));
        tbl.push_back(mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h40,       1, 1, 32'h80,       8, 5));
        tbl.push_back(mk(0, 1, 32'h50, 1, 32'h90, 0, 32'h50,       1, 0, 32'h51,       8, 5));
        tbl.push_back(mk(0, 1, 32'h60, 0, 32'h0,  0, 32'h40,       1, 0, 32'h41,       9, 6));
        tbl.push_back(mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h50,       1, 1, 32'h90,      10, 6));
        tbl.push_back(mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h60,       1, 0, 32'h61,      10, 6));
        tbl.push_back(mk(0, 0, 32'h0,  0, 32'h0,  0, 32'hFFFFFFFF, 1, 0, 32'h0,       10, 6));
        tbl.push_back(mk(1, 1, 32'h50, 1, 32'h90, 0, 32'h50,       1, 1, 32'h90,      10, 6));
        tbl.push_back(mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h50,       1, 0, 32'h51,       0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            v.id = i;
            apply(v);
        end

        // Perf-counter saturation: 20 mispredicted updates after a fresh reset
        apply(mk(1, 0, 32'h0, 0, 32'h0, 0, 32'h3FF, 0, 0, 32'h0, 0, 0));
        for (int i = 0; i <= 20; i++) begin
            logic t;
            t = 1'(i % 2);
            v = mk(0, (i < 20) ? 1'b1 : 1'b0, 32'h200 + 32'(i % 8), t, 32'h300 + 32'(i),
                   ~t, 32'h3FF, 1, 0, 32'h400, i, i);
            v.id    = 100 + i;
            v.euc_c = (i > 15) ? 15 : i;
            v.emc_c = (i > 15) ? 15 : i;
            apply(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
